// File: rtl/axi_store_throttle_pkg.sv
// Shared types for the store throttle: AXI response codes and the counter width helper.
package axi_store_throttle_pkg;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } resp_t;

    // Bits needed to hold 0..max_out inclusive.
    function automatic int cnt_width(input int max_out);
        return $clog2(max_out + 1);
    endfunction

endpackage

// File: rtl/axi_store_throttle_if.sv
// AXI4 write-channel bundle (AW, W, B) used on both the upstream and downstream side of the throttle.
interface axi_store_throttle_if
    import axi_store_throttle_pkg::*;
#(
    parameter int ID_W   = 4,
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    logic                aw_valid;
    logic                aw_ready;
    logic [ADDR_W-1:0]   aw_addr;
    logic [ID_W-1:0]     aw_id;

    logic                w_valid;
    logic                w_ready;
    logic [DATA_W-1:0]   w_data;
    logic [DATA_W/8-1:0] w_strb;
    logic                w_last;

    logic                b_valid;
    logic                b_ready;
    logic [ID_W-1:0]     b_id;
    resp_t               b_resp;

    modport master (
        output aw_valid, aw_addr, aw_id,
        input  aw_ready,
        output w_valid, w_data, w_strb, w_last,
        input  w_ready,
        input  b_valid, b_id, b_resp,
        output b_ready
    );

    modport slave (
        input  aw_valid, aw_addr, aw_id,
        output aw_ready,
        input  w_valid, w_data, w_strb, w_last,
        output w_ready,
        output b_valid, b_id, b_resp,
        input  b_ready
    );

endinterface

// File: rtl/axi_store_throttle.sv
// Caps outstanding AXI writes, holds each W burst behind its AW, and provides fence drain
// plus a sticky write-error flag.
module axi_store_throttle
    import axi_store_throttle_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 7,
    parameter int AXI_ID_WIDTH    = 4,
    parameter int AXI_ADDR_WIDTH  = 64,
    parameter int AXI_DATA_WIDTH  = 64
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    axi_store_throttle_if.slave         s_port,
    axi_store_throttle_if.master        m_port,
    input  logic                        fence_req_i,
    output logic                        drained_o,
    output logic                        wr_err_o,
    input  logic                        wr_err_clr_i
);

    localparam int CW = cnt_width(MAX_OUTSTANDING);
    typedef logic [CW-1:0] cnt_t;
    localparam cnt_t MAX_CNT = cnt_t'(MAX_OUTSTANDING);

    cnt_t r_out_cnt;
    cnt_t r_w_pend;
    logic r_drained;
    logic r_wr_err;

    cnt_t w_out_cnt_next;
    cnt_t w_w_pend_next;
    logic w_aw_ok;
    logic w_aw_hs;
    logic w_w_gate;
    logic w_w_last_hs;
    logic w_b_hs;
    logic w_b_err;

    // Gated by rst_ni so no handshake can complete while reset is held.
    assign w_aw_ok     = rst_ni & ~fence_req_i & (r_out_cnt < MAX_CNT) & (r_w_pend < MAX_CNT);
    assign w_aw_hs     = s_port.aw_valid & m_port.aw_ready & w_aw_ok;
    assign w_w_gate    = rst_ni & ((r_w_pend != '0) | w_aw_hs);
    assign w_w_last_hs = s_port.w_valid & m_port.w_ready & w_w_gate & s_port.w_last;
    assign w_b_hs      = rst_ni & m_port.b_valid & s_port.b_ready;
    assign w_b_err     = (m_port.b_resp == RESP_SLVERR) | (m_port.b_resp == RESP_DECERR);

    assign m_port.aw_valid = s_port.aw_valid & w_aw_ok;
    assign s_port.aw_ready = m_port.aw_ready & w_aw_ok;
    assign m_port.aw_addr  = s_port.aw_addr;
    assign m_port.aw_id    = s_port.aw_id;

    assign m_port.w_valid  = s_port.w_valid & w_w_gate;
    assign s_port.w_ready  = m_port.w_ready & w_w_gate;
    assign m_port.w_data   = s_port.w_data;
    assign m_port.w_strb   = s_port.w_strb;
    assign m_port.w_last   = s_port.w_last;

    assign s_port.b_valid  = rst_ni & m_port.b_valid;
    assign m_port.b_ready  = rst_ni & s_port.b_ready;
    assign s_port.b_id     = m_port.b_id;
    assign s_port.b_resp   = m_port.b_resp;

    assign drained_o = r_drained;
    assign wr_err_o  = r_wr_err;

    always_comb begin
        w_out_cnt_next = r_out_cnt;
        w_w_pend_next  = r_w_pend;
        if (w_aw_hs && !w_b_hs) begin
            w_out_cnt_next = r_out_cnt + cnt_t'(1);
        end else if (!w_aw_hs && w_b_hs && (r_out_cnt != '0)) begin
            // A stray B at zero is a protocol error; the count saturates rather than wrapping.
            w_out_cnt_next = r_out_cnt - cnt_t'(1);
        end
        if (w_aw_hs && !w_w_last_hs) begin
            w_w_pend_next = r_w_pend + cnt_t'(1);
        end else if (!w_aw_hs && w_w_last_hs) begin
            w_w_pend_next = r_w_pend - cnt_t'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_out_cnt <= '0;
            r_w_pend  <= '0;
            r_drained <= 1'b0;
            r_wr_err  <= 1'b0;
        end else begin
            r_out_cnt <= w_out_cnt_next;
            r_w_pend  <= w_w_pend_next;
            r_drained <= fence_req_i & (w_out_cnt_next == '0) & (w_w_pend_next == '0);
            if (w_b_hs && w_b_err) begin
                r_wr_err <= 1'b1;
            end else if (wr_err_clr_i) begin
                r_wr_err <= 1'b0;
            end
        end
    end

    a_cnt_max: assert property (@(posedge clk_i) disable iff (!rst_ni)
        r_out_cnt <= MAX_CNT);
    a_w_after_aw: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (m_port.w_valid && m_port.w_ready) |-> ((r_w_pend != '0) || w_aw_hs));
    a_b_not_idle: assert property (@(posedge clk_i) disable iff (!rst_ni)
        w_b_hs |-> (r_out_cnt != '0));

endmodule

// File: tb/tb_axi_store_throttle.sv
// Directed scenarios plus randomized traffic against a cycle-level counting model of the throttle.
module tb_axi_store_throttle;
    import axi_store_throttle_pkg::*;

    localparam int MAXO = 7;
    localparam int IDW  = 4;
    localparam int AW   = 64;
    localparam int DW   = 64;

    logic clk_i = 1'b0;
    logic rst_ni = 1'b0;
    logic fence_req_i = 1'b0;
    logic wr_err_clr_i = 1'b0;
    logic drained_o;
    logic wr_err_o;

    always #5 clk_i = ~clk_i;

    axi_store_throttle_if #(.ID_W(IDW), .ADDR_W(AW), .DATA_W(DW)) s_if ();
    axi_store_throttle_if #(.ID_W(IDW), .ADDR_W(AW), .DATA_W(DW)) m_if ();

    axi_store_throttle #(
        .MAX_OUTSTANDING(MAXO),
        .AXI_ID_WIDTH   (IDW),
        .AXI_ADDR_WIDTH (AW),
        .AXI_DATA_WIDTH (DW)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .s_port      (s_if),
        .m_port      (m_if),
        .fence_req_i (fence_req_i),
        .drained_o   (drained_o),
        .wr_err_o    (wr_err_o),
        .wr_err_clr_i(wr_err_clr_i)
    );

    int n_checks = 0;
    int n_errs   = 0;

    // Model state: writes without B, bursts without W last, and the two registered flags.
    int mdl_cnt  = 0;
    int mdl_pend = 0;
    bit mdl_err  = 1'b0;
    bit mdl_drained = 1'b0;

    bit e_aw_ok, e_aw_hs, e_w_gate, e_w_hs, e_b_hs;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chkv(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle model comparison at the falling edge, well away from the active edge.
    always @(negedge clk_i) begin
        if (!rst_ni) begin
            chk1("rst_m_aw_valid", m_if.aw_valid, 1'b0);
            chk1("rst_s_aw_ready", s_if.aw_ready, 1'b0);
            chk1("rst_m_w_valid",  m_if.w_valid,  1'b0);
            chk1("rst_s_w_ready",  s_if.w_ready,  1'b0);
            chk1("rst_s_b_valid",  s_if.b_valid,  1'b0);
            chk1("rst_m_b_ready",  m_if.b_ready,  1'b0);
            chk1("rst_drained",    drained_o,     1'b0);
            chk1("rst_wr_err",     wr_err_o,      1'b0);
            mdl_cnt = 0;
            mdl_pend = 0;
            mdl_err = 1'b0;
            mdl_drained = 1'b0;
        end else begin
            e_aw_ok  = !fence_req_i && (mdl_cnt < MAXO) && (mdl_pend < MAXO);
            e_aw_hs  = s_if.aw_valid && m_if.aw_ready && e_aw_ok;
            e_w_gate = (mdl_pend > 0) || e_aw_hs;
            e_w_hs   = s_if.w_valid && m_if.w_ready && e_w_gate;
            e_b_hs   = m_if.b_valid && s_if.b_ready;

            chk1("m_aw_valid", m_if.aw_valid, s_if.aw_valid && e_aw_ok);
            chk1("s_aw_ready", s_if.aw_ready, m_if.aw_ready && e_aw_ok);
            chk1("m_w_valid",  m_if.w_valid,  s_if.w_valid && e_w_gate);
            chk1("s_w_ready",  s_if.w_ready,  m_if.w_ready && e_w_gate);
            chk1("s_b_valid",  s_if.b_valid,  m_if.b_valid);
            chk1("m_b_ready",  m_if.b_ready,  s_if.b_ready);
            chk1("drained",    drained_o,     mdl_drained);
            chk1("wr_err",     wr_err_o,      mdl_err);
            if (m_if.aw_valid) begin
                chkv("aw_addr", m_if.aw_addr, s_if.aw_addr);
                chkv("aw_id",   64'(m_if.aw_id), 64'(s_if.aw_id));
            end
            if (m_if.w_valid) begin
                chkv("w_data", m_if.w_data, s_if.w_data);
                chkv("w_strb", 64'(m_if.w_strb), 64'(s_if.w_strb));
                chk1("w_last", m_if.w_last, s_if.w_last);
            end
            if (s_if.b_valid) begin
                chkv("b_id",   64'(s_if.b_id),   64'(m_if.b_id));
                chkv("b_resp", 64'(s_if.b_resp), 64'(m_if.b_resp));
            end

            mdl_cnt  = mdl_cnt + int'(e_aw_hs) - int'(e_b_hs);
            mdl_pend = mdl_pend + int'(e_aw_hs) - int'(e_w_hs && s_if.w_last);
            if (e_b_hs && (m_if.b_resp == RESP_SLVERR || m_if.b_resp == RESP_DECERR))
                mdl_err = 1'b1;
            else if (wr_err_clr_i)
                mdl_err = 1'b0;
            mdl_drained = fence_req_i && (mdl_cnt == 0) && (mdl_pend == 0);
        end
    end

    task automatic drive(input bit awv, input bit awr, input bit wv, input bit wl, input bit wr,
                         input bit bv, input bit br, input logic [1:0] resp,
                         input bit fence, input bit clr);
        s_if.aw_valid = awv;
        m_if.aw_ready = awr;
        s_if.aw_addr  = {$urandom, $urandom};
        s_if.aw_id    = 4'($urandom);
        s_if.w_valid  = wv;
        s_if.w_last   = wl;
        s_if.w_data   = {$urandom, $urandom};
        s_if.w_strb   = 8'($urandom);
        m_if.w_ready  = wr;
        m_if.b_valid  = bv;
        s_if.b_ready  = br;
        m_if.b_id     = 4'($urandom);
        m_if.b_resp   = resp_t'(resp);
        fence_req_i   = fence;
        wr_err_clr_i  = clr;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        bit fence_r;
        // Reset held with every input valid high: nothing may leak out.
        drive(1, 1, 1, 1, 1, 1, 1, 2'b10, 0, 0);
        #1;
        chk1("lit_rst_m_aw_valid", m_if.aw_valid, 1'b0);
        chk1("lit_rst_m_w_valid",  m_if.w_valid,  1'b0);
        chk1("lit_rst_s_b_valid",  s_if.b_valid,  1'b0);
        chk1("lit_rst_drained",    drained_o,     1'b0);
        chk1("lit_rst_wr_err",     wr_err_o,      1'b0);
        tick();
        tick();
        rst_ni = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
        tick();
        $display("reset released");

        for (int i = 0; i < MAXO; i++) begin
            drive(1, 1, 1, 1, 1, 0, 0, 2'b00, 0, 0);
            #1 chk1("fill_aw_ready", s_if.aw_ready, 1'b1);
            $display("fill: AW %0d issued", i);
            tick();
        end
        drive(1, 1, 1, 1, 1, 0, 0, 2'b00, 0, 0);
        #1;
        chk1("full_aw_ready",  s_if.aw_ready, 1'b0);
        chk1("full_m_aw_valid", m_if.aw_valid, 1'b0);
        chk1("full_w_blocked", m_if.w_valid,  1'b0);
        tick();
        drive(1, 1, 0, 1, 1, 1, 1, 2'b00, 0, 0);
        #1 chk1("full_b_no_comb_path", s_if.aw_ready, 1'b0);
        tick();
        drive(1, 1, 1, 1, 1, 0, 0, 2'b00, 0, 0);
        #1;
        chk1("reopen_aw_ready", s_if.aw_ready, 1'b1);
        chk1("reopen_w_valid",  m_if.w_valid,  1'b1);
        tick();
        drive(1, 1, 0, 1, 1, 0, 0, 2'b00, 0, 0);
        #1 chk1("refull_aw_ready", s_if.aw_ready, 1'b0);
        tick();
        $display("full: 8th AW stalled, issued after one B");
        repeat (MAXO) begin
            drive(0, 0, 0, 0, 0, 1, 1, 2'b00, 0, 0);
            tick();
        end

        repeat (3) begin
            drive(0, 1, 1, 1, 1, 0, 0, 2'b00, 0, 0);
            #1;
            chk1("early_w_valid", m_if.w_valid, 1'b0);
            chk1("early_w_ready", s_if.w_ready, 1'b0);
            tick();
        end
        drive(1, 1, 1, 1, 1, 0, 0, 2'b00, 0, 0);
        #1;
        chk1("w_with_aw_valid", m_if.w_valid,  1'b1);
        chk1("w_with_aw_ready", s_if.aw_ready, 1'b1);
        tick();
        $display("early W: held until AW handshake");

        // Bring to 4 outstanding / 3 pending, then AW+B+W last together.
        repeat (3) begin
            drive(1, 1, 0, 0, 0, 0, 0, 2'b00, 0, 0);
            tick();
        end
        drive(1, 1, 1, 1, 1, 1, 1, 2'b00, 0, 0);
        tick();
        repeat (3) begin
            drive(0, 0, 1, 1, 1, 0, 0, 2'b00, 0, 0);
            tick();
        end
        repeat (3) begin
            drive(1, 1, 1, 1, 1, 0, 0, 2'b00, 0, 0);
            #1 chk1("same_cycle_room", s_if.aw_ready, 1'b1);
            tick();
        end
        drive(1, 1, 1, 1, 1, 0, 0, 2'b00, 0, 0);
        #1 chk1("same_cycle_count_held", s_if.aw_ready, 1'b0);
        tick();
        repeat (MAXO) begin
            drive(0, 0, 0, 0, 0, 1, 1, 2'b00, 0, 0);
            tick();
        end
        drive(0, 0, 0, 0, 0, 0, 0, 2'b00, 1, 0);
        tick();
        chk1("same_cycle_drained", drained_o, 1'b1);
        drive(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
        tick();
        chk1("same_cycle_undrained", drained_o, 1'b0);
        $display("same-cycle AW/B and AW/W-last: counts held");

        repeat (2) begin
            drive(1, 1, 1, 1, 1, 0, 0, 2'b00, 0, 0);
            tick();
        end
        drive(1, 1, 0, 0, 0, 0, 0, 2'b00, 1, 0);
        #1;
        chk1("fence_aw_ready",  s_if.aw_ready, 1'b0);
        chk1("fence_m_aw_valid", m_if.aw_valid, 1'b0);
        tick();
        chk1("fence_not_drained", drained_o, 1'b0);
        drive(0, 0, 0, 0, 0, 1, 1, 2'b00, 1, 0);
        tick();
        drive(0, 0, 0, 0, 0, 1, 1, 2'b00, 1, 0);
        #1 chk1("fence_drain_latency", drained_o, 1'b0);
        tick();
        chk1("fence_drained", drained_o, 1'b1);
        drive(1, 1, 1, 1, 1, 0, 0, 2'b00, 0, 0);
        #1;
        chk1("fence_release_aw", s_if.aw_ready, 1'b1);
        chk1("fence_drained_reg", drained_o, 1'b1);
        tick();
        chk1("fence_release_drained", drained_o, 1'b0);
        $display("fence: drained after 2 B, AW resumed");

        drive(0, 0, 0, 0, 0, 1, 1, 2'b10, 0, 0);
        tick();
        chk1("err_set_slverr", wr_err_o, 1'b1);
        drive(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
        tick();
        chk1("err_sticky", wr_err_o, 1'b1);
        drive(1, 1, 1, 1, 1, 0, 0, 2'b00, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 1, 1, 2'b11, 0, 1);
        tick();
        chk1("err_set_wins_clr", wr_err_o, 1'b1);
        drive(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 1);
        tick();
        chk1("err_cleared", wr_err_o, 1'b0);
        $display("wr_err: set, held, set-over-clear, cleared");

        repeat (3) begin
            drive(1, 1, 1, 1, 1, 0, 0, 2'b00, 0, 0);
            tick();
        end
        repeat (2) begin
            drive(1, 1, 0, 0, 0, 0, 0, 2'b00, 0, 0);
            tick();
        end
        drive(1, 1, 1, 1, 1, 1, 1, 2'b10, 0, 0);
        rst_ni = 1'b0;
        #1;
        chk1("async_rst_m_aw_valid", m_if.aw_valid, 1'b0);
        chk1("async_rst_s_aw_ready", s_if.aw_ready, 1'b0);
        chk1("async_rst_m_w_valid",  m_if.w_valid,  1'b0);
        chk1("async_rst_s_b_valid",  s_if.b_valid,  1'b0);
        chk1("async_rst_m_b_ready",  m_if.b_ready,  1'b0);
        tick();
        rst_ni = 1'b1;
        drive(0, 0, 1, 1, 1, 0, 0, 2'b00, 1, 0);
        #1 chk1("rst_w_pend_cleared", m_if.w_valid, 1'b0);
        tick();
        chk1("rst_cnt_cleared", drained_o, 1'b1);
        chk1("rst_err_cleared", wr_err_o, 1'b0);
        drive(1, 1, 1, 1, 1, 0, 0, 2'b00, 0, 0);
        #1 chk1("rst_first_aw", s_if.aw_ready, 1'b1);
        tick();
        $display("async reset mid-traffic: state cleared, AW accepted");

        fence_r = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 39) == 0) fence_r = !fence_r;
            drive($urandom_range(0, 2) != 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 1) == 1, $urandom_range(0, 2) != 0,
                  $urandom_range(0, 3) != 0,
                  (mdl_cnt > 0) && ($urandom_range(0, 2) == 0),
                  $urandom_range(0, 3) != 0, 2'($urandom),
                  fence_r, $urandom_range(0, 15) == 0);
            tick();
        end
        $display("random: 3000 cycles of mixed traffic");

        drive(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
        tick();
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
